// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - decode-stage bus for the scoreboarded register file
//
// Purpose: groups the read ports, the issue port and the write-back port of
// regfile_sb so decode (master) and the register file (slave) share one bundle.
// Signals:
//   rd_addr   NRD packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data   NRD packed read values, port i at [i*DATA_W +: DATA_W]
//   rd_busy   per read port: register has an unresolved pending write
//   iss_en    issue request for destination iss_addr
//   iss_addr  destination of the issuing instruction
//   iss_ready issue can be accepted this cycle
//   wr_en     write-back valid
//   wr_addr   write-back destination
//   wr_data   write-back value
//   wb_orphan sticky: write-back seen for a register with no pending write
interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic                  iss_en;
  logic [ADDR_W-1:0]     iss_addr;
  logic                  iss_ready;
  logic                  wr_en;
  logic [ADDR_W-1:0]     wr_addr;
  logic [DATA_W-1:0]     wr_data;
  logic                  wb_orphan;

  modport master (
    output rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
    input  rd_data, rd_busy, iss_ready, wb_orphan
  );

  modport slave (
    input  rd_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
    output rd_data, rd_busy, iss_ready, wb_orphan
  );
endinterface

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with per-register pending-write scoreboard
//
// Purpose: NREG x DATA_W register file with NRD combinational read ports
// (optional write-to-read bypass), one write-back port and a saturating
// pending-write counter per register, so decode can stall on RAW hazards.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; clears data, counters and wb_orphan
//   bus    regfile_sb_if slave modport (reads, issue, write-back, wb_orphan)
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int CNT_W  = 2,
  parameter int BYPASS = 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_sb_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0]     regs_q [NREG];
  logic [CNT_W-1:0]      cnt_q  [NREG];
  logic [CNT_W-1:0]      cnt_d  [NREG];
  logic                  orphan_q;
  logic                  orphan_d;

  logic                  wr_act;
  logic                  wr_cnt_nz;
  logic                  iss_ready;
  logic                  iss_act;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;

  // Inputs are ignored while reset is held low, including the read bypass,
  // so outputs reflect the cleared state immediately.
  assign wr_act    = reset && bus.wr_en && (bus.wr_addr != '0);
  assign wr_cnt_nz = (cnt_q[bus.wr_addr] != '0);

  // A full counter can still take a new issue when the same register is
  // being retired this cycle: the increment and decrement cancel.
  always_comb begin
    iss_ready = 1'b1;
    if ((bus.iss_addr != '0) && (cnt_q[bus.iss_addr] == CNT_MAX) &&
        !(wr_act && (bus.wr_addr == bus.iss_addr) && wr_cnt_nz)) begin
      iss_ready = 1'b0;
    end
  end

  assign iss_act = reset && bus.iss_en && iss_ready && (bus.iss_addr != '0);

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic              byp;
    rd_data = '0;
    rd_busy = '0;
    a       = '0;
    byp     = 1'b0;
    for (int i = 0; i < NRD; i++) begin
      a   = bus.rd_addr[i*ADDR_W +: ADDR_W];
      byp = (BYPASS != 0) && wr_act && (bus.wr_addr == a);
      if (a != '0) begin
        rd_data[i*DATA_W +: DATA_W] = byp ? bus.wr_data : regs_q[a];
        // Busy clears in the write-back cycle only when forwarding retires
        // the last outstanding write.
        rd_busy[i] = (cnt_q[a] != '0) && !(byp && (cnt_q[a] == CNT_ONE));
      end
    end
  end

  always_comb begin
    logic inc;
    logic dec;
    inc      = 1'b0;
    dec      = 1'b0;
    orphan_d = orphan_q | (wr_act && !wr_cnt_nz);
    for (int r = 0; r < NREG; r++) begin
      inc      = iss_act && (bus.iss_addr == ADDR_W'(r));
      dec      = wr_act && (bus.wr_addr == ADDR_W'(r));
      cnt_d[r] = cnt_q[r];
      if (inc && !dec) begin
        cnt_d[r] = cnt_q[r] + CNT_ONE;
      end else if (dec && !inc && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      orphan_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (wr_act) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
      orphan_q <= orphan_d;
    end
  end

  assign bus.rd_data   = rd_data;
  assign bus.rd_busy   = rd_busy;
  assign bus.iss_ready = iss_ready;
  assign bus.wb_orphan = orphan_q;

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with an integrated per-register write scoreboard, for the pipelined CPU's decode stage. Provides NRD combinational read ports with write-to-read bypass, one write-back port, and per-register pending-write counters. Counters are incremented at instruction issue and decremented at write-back, so decode sees a per-port busy flag and can stall on RAW hazards without a separate hazard table.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; NREG = 2**ADDR_W registers
- NRD, 2, number of read ports (1..4)
- CNT_W, 2, pending-counter width; at most 2**CNT_W-1 outstanding writes per register
- BYPASS, 1, 1 = same-cycle write-back forwarded to read ports; 0 = no forwarding
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr  in  NRD*ADDR_W  read indices; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  read register has an unresolved pending write, combinational
- iss_en  in  1  issue request: an instruction with destination iss_addr enters the pipeline
- iss_addr  in  ADDR_W  destination of the issuing instruction
- iss_ready  out  1  issue can be accepted this cycle, combinational
- wr_en  in  1  write-back valid
- wr_addr  in  ADDR_W  write-back destination
- wr_data  in  DATA_W  write-back value
- wb_orphan  out  1  sticky error: write-back arrived to a register with zero pending count

## Operation
- Storage: NREG x DATA_W registers; cnt[r] is a CNT_W-bit pending counter per register.
- Register 0 is hardwired:
  - Reads return 0.
  - Writes are discarded.
  - cnt[0] stays 0.
  - Issues to 0 are always accepted and have no effect.
- Read, port i, address a:
  - a == 0: 0.
  - BYPASS && wr_en && wr_addr == a: wr_data.
  - Otherwise: reg[a].
- Busy, port i:
  - a != 0 && (cnt[a] - dec(a)) != 0.
  - dec(a) = 1 when wr_en && wr_addr == a && BYPASS && cnt[a] != 0; otherwise 0.
  - With BYPASS=0, a same-cycle write-back does not clear busy.
- iss_ready:
  - 0 when iss_addr != 0 and cnt[iss_addr] == 2**CNT_W-1 and no same-cycle decrement of iss_addr.
  - 1 otherwise.
  - An issue takes effect only when iss_en && iss_ready.
- Write-back: wr_en && wr_addr != 0 writes reg[wr_addr] <= wr_data at the edge.
  - If cnt[wr_addr] != 0: cnt[wr_addr] decrements.
  - If cnt[wr_addr] == 0: data is still written, the counter stays 0, and wb_orphan is set.
- Simultaneous accepted issue and write-back to the same register: the counter is unchanged (net 0). Data is written.
- Issue and write-back to different registers: each counter updates independently.
- Counters never wrap. Increment is blocked by iss_ready; decrement saturates at 0.
- wb_orphan is cleared only by reset.

## Timing
- Read, busy and iss_ready are purely combinational from current state and same-cycle inputs: zero latency.
- Register and counter updates are visible on outputs the cycle after the edge.
- Reset (reset = 0), asynchronous and immediate:
  - All registers 0, all cnt 0, wb_orphan 0.
  - Outputs become rd_data = 0, rd_busy = 0, iss_ready = 1.
- While reset is low, iss_en and wr_en are ignored. Reset asserted mid-operation discards all pending counts and data.
- Release is synchronous in effect: the first edge with reset = 1 processes inputs normally.

## Test plan
- Reset mid-run: write reg5 = 32'hDEAD_BEEF, assert reset low between edges -> rd_data for addr 5 is 0 immediately; cnt cleared; iss_ready = 1.
- Issue then write-back: issue to 3 at cycle 0 -> rd_busy for addr 3 = 1 at cycle 1.
  - Write-back wr_addr=3, wr_data=32'h1234 at cycle 2 -> same cycle rd_data = 32'h1234, rd_busy = 0 (BYPASS=1).
  - Cycle 3: stored value 32'h1234.
- Counter saturation (CNT_W=2): issue to 7 three times -> iss_ready = 0 with iss_addr=7.
  - Fourth issue is ignored.
  - Same cycle wr_en to 7 -> iss_ready = 1 and the count stays 3.
- Simultaneous issue and write-back to 9 with cnt = 1 -> cnt stays 1, reg9 updated, rd_busy for addr 9 = 1 next cycle.
- Register 0: issue to 0 and write 32'hFFFF_FFFF to 0 -> rd_data for addr 0 = 0, rd_busy = 0, wb_orphan stays 0.
- Orphan write-back: wr_en to 12 with cnt = 0, data 32'h55 -> reg12 = 32'h55 next cycle; wb_orphan = 1 and stays 1 until reset.
